prover_shim_chi: RTL and testbench

PROVER_SHIM_CHI -- requirements
Module: prover_shim_chi

---
 rtl/prover_shim_chi_pkg.sv | 28 ++
 rtl/prover_shim_chi_mul.sv | 41 ++++
 rtl/prover_shim_chi.sv | 154 +++++++++++++++
 tb/tb_prover_shim_chi.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/prover_shim_chi_pkg.sv
// Shared field arithmetic: element width, prime and a modular multiply.
// Latency: combinational helper only.
// Backpressure: none (package has no ports).
package prover_shim_chi_pkg;

    localparam int F_NBITS = 61;
    localparam logic [F_NBITS-1:0] F_PRIME = {F_NBITS{1'b1}};   // 2^61 - 1

    // The prime is a Mersenne number. So the high half of the product folds
    // onto the low half: 2^61 is congruent to 1.
    function automatic logic [F_NBITS-1:0] field_mul(
        input logic [F_NBITS-1:0] a,
        input logic [F_NBITS-1:0] b
    );
        logic [2*F_NBITS-1:0] p;
        logic [F_NBITS:0]     s;
        logic [F_NBITS:0]     t;
        p = (2*F_NBITS)'(a) * (2*F_NBITS)'(b);
        s = {1'b0, p[F_NBITS-1:0]} + {1'b0, p[2*F_NBITS-1:F_NBITS]};
        t = {1'b0, s[F_NBITS-1:0]} + {{F_NBITS{1'b0}}, s[F_NBITS]};
        // t can be at most 2^61, which is one past the prime.
        if (t >= {1'b0, F_PRIME}) begin
            t = t - {1'b0, F_PRIME};
        end
        return t[F_NBITS-1:0];
    endfunction

endpackage

// File: rtl/prover_shim_chi_mul.sv
// Field multiplier with an en/ready handshake. Operands are captured on en.
// Latency: 1..MAX_LAT cycles after en. An internal LFSR picks the latency per operation.
// Backpressure: ready is low while en is high and while an operation is in flight.
// Ports: clk, rst, en, a, b -> result, ready.
module field_multiplier
    import prover_shim_chi_pkg::*;
#(
    parameter int MAX_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [F_NBITS-1:0] a,
    input  logic [F_NBITS-1:0] b,
    output logic [F_NBITS-1:0] result,
    output logic               ready
);

    logic [7:0] cnt_q;
    logic [7:0] lfsr_q;

    assign ready = ~en & (cnt_q == 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            cnt_q  <= '0;
            lfsr_q <= 8'h01;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            if (en) begin
                result <= field_mul(a, b);
                // Extra wait cycles are 0..MAX_LAT-1. When MAX_LAT is 1, every operation takes one cycle.
                cnt_q  <= lfsr_q % 8'(MAX_LAT);
            end else if (cnt_q != 8'd0) begin
                cnt_q <= cnt_q - 8'd1;
            end
        end
    end

endmodule

// File: rtl/prover_shim_chi.sv
// Builds the multilinear chi table: chi[g] = prod_i (g[i] ? z[i] : 1-z[i]).
// Latency: 2 + 3*(2*(2^nBits-2)) cycles from start with a 1-cycle multiplier.
// Backpressure: a start is accepted only in idle; ready reports that.
// Ports: clk, rst, en (a rising edge starts), z, m_z_p1 -> chi, ready, ready_pulse.
module prover_shim_chi
    import prover_shim_chi_pkg::*;
#(
    parameter int nBits       = 2,
    parameter int MUL_MAX_LAT = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [nBits*F_NBITS-1:0]       z,
    input  logic [nBits*F_NBITS-1:0]       m_z_p1,
    output logic [(2**nBits)*F_NBITS-1:0]  chi,
    output logic                           ready,
    output logic                           ready_pulse
);

    localparam int N_ENT = 2**nBits;
    localparam int BIT_W = $clog2(nBits) + 1;
    localparam int N_SEL = 2**BIT_W;

    typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_MUL_ST, ST_MUL_WAIT, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic               en_dly;
    logic               start;
    logic [F_NBITS-1:0] z_l   [N_SEL];
    logic [F_NBITS-1:0] m_l   [N_SEL];
    logic [F_NBITS-1:0] chi_q [N_ENT];
    logic [BIT_W-1:0]   bit_q;
    logic [nBits-1:0]   j_q;
    logic               phase_lo;
    logic               mul_en_q;
    logic [F_NBITS-1:0] mul_b;
    logic [F_NBITS-1:0] mul_res;
    logic               mul_rdy;
    logic [nBits-1:0]   j_inc;
    logic [nBits-1:0]   span;
    logic [nBits-1:0]   hi_idx;
    logic               last_lo;

    assign start   = en & ~en_dly;
    assign ready   = (state_q == ST_IDLE) & ~start;
    assign j_inc   = j_q + nBits'(1);
    assign span    = nBits'(1) << bit_q;
    assign hi_idx  = j_q + span;
    assign last_lo = (j_inc == span) && (bit_q == BIT_W'(nBits - 1));
    assign mul_b   = phase_lo ? m_l[bit_q] : z_l[bit_q];

    for (genvar g = 0; g < N_ENT; g++) begin : g_chi
        assign chi[g*F_NBITS +: F_NBITS] = chi_q[g];
    end

    field_multiplier #(.MAX_LAT(MUL_MAX_LAT)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .en     (mul_en_q),
        .a      (chi_q[j_q]),
        .b      (mul_b),
        .result (mul_res),
        .ready  (mul_rdy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start) state_d = ST_INIT;
            ST_INIT:     state_d = (nBits == 1) ? ST_DONE : ST_MUL_ST;
            ST_MUL_ST:   state_d = ST_MUL_WAIT;
            ST_MUL_WAIT: begin
                if (mul_rdy) begin
                    if (phase_lo && last_lo) state_d = ST_DONE;
                    else                     state_d = ST_MUL_ST;
                end
            end
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // An en held high through reset must not look like a rising edge.
            en_dly      <= 1'b1;
            ready_pulse <= 1'b0;
            mul_en_q    <= 1'b0;
            bit_q       <= '0;
            j_q         <= '0;
            phase_lo    <= 1'b0;
            for (int i = 0; i < N_SEL; i++) begin
                z_l[i] <= '0;
                m_l[i] <= '0;
            end
            for (int g = 0; g < N_ENT; g++) begin
                chi_q[g] <= '0;
            end
        end else begin
            en_dly      <= en;
            ready_pulse <= (state_d == ST_DONE);
            mul_en_q    <= (state_q == ST_MUL_ST);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < nBits; i++) begin
                            z_l[i] <= z[i*F_NBITS +: F_NBITS];
                            m_l[i] <= m_z_p1[i*F_NBITS +: F_NBITS];
                        end
                    end
                end
                ST_INIT: begin
                    for (int g = 0; g < N_ENT; g++) begin
                        chi_q[g] <= '0;
                    end
                    chi_q[0] <= m_l[0];
                    chi_q[1] <= z_l[0];
                    bit_q    <= BIT_W'(1);
                    j_q      <= '0;
                    phase_lo <= 1'b0;
                end
                ST_MUL_WAIT: begin
                    if (mul_rdy) begin
                        // The HI half goes first. It reads chi[j] before the LO half overwrites it.
                        if (!phase_lo) begin
                            chi_q[hi_idx] <= mul_res;
                            phase_lo      <= 1'b1;
                        end else begin
                            chi_q[j_q] <= mul_res;
                            phase_lo   <= 1'b0;
                            if (j_inc == span) begin
                                j_q   <= '0;
                                bit_q <= bit_q + BIT_W'(1);
                            end else begin
                                j_q <= j_inc;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prover_shim_chi.sv
// Self-checking bench for prover_shim_chi at sizes 1, 2 and 3.
// Latency: checked against the closed-form cycle count for a 1-cycle multiplier.
// Backpressure: checks restart rejection, reset abort and input latching.
module tb_prover_shim_chi;
    import prover_shim_chi_pkg::*;

    logic                   clk, rst;
    logic                   en1, en2, en3;
    logic [F_NBITS-1:0]     z1, m1;
    logic [2*F_NBITS-1:0]   z2, m2;
    logic [3*F_NBITS-1:0]   z3, m3;
    logic [2*F_NBITS-1:0]   chi1;
    logic [4*F_NBITS-1:0]   chi2;
    logic [8*F_NBITS-1:0]   chi3;
    logic                   rdy1, rdy2, rdy3, rp1, rp2, rp3;
    logic [8*F_NBITS-1:0]   zs, ms;

    int n_vec = 0;
    int n_err = 0;
    int mc1 = 0, mc2 = 0, mc3 = 0;
    int k, snap, bad, extra;
    logic seen;

    prover_shim_chi #(.nBits(1), .MUL_MAX_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .z(z1), .m_z_p1(m1),
        .chi(chi1), .ready(rdy1), .ready_pulse(rp1));
    prover_shim_chi #(.nBits(2), .MUL_MAX_LAT(1)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .z(z2), .m_z_p1(m2),
        .chi(chi2), .ready(rdy2), .ready_pulse(rp2));
    prover_shim_chi #(.nBits(3), .MUL_MAX_LAT(5)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .z(z3), .m_z_p1(m3),
        .chi(chi3), .ready(rdy3), .ready_pulse(rp3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dut1.u_mul.en === 1'b1) mc1++;
        if (dut2.u_mul.en === 1'b1) mc2++;
        if (dut3.u_mul.en === 1'b1) mc3++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: direct product over all coordinates, using wide arithmetic and %.
    function automatic logic [63:0] ref_chi(input int nb, input logic [8*F_NBITS-1:0] zv,
                                            input logic [8*F_NBITS-1:0] mv, input int g);
        logic [127:0] acc, f;
        acc = 128'd1;
        for (int i = 0; i < nb; i++) begin
            if (((g >> i) & 1) == 1) f = 128'(zv[i*F_NBITS +: F_NBITS]);
            else                     f = 128'(mv[i*F_NBITS +: F_NBITS]);
            acc = (acc * f) % 128'(F_PRIME);
        end
        return acc[63:0];
    endfunction

    function automatic logic [F_NBITS-1:0] rand_fe();
        logic [63:0] r;
        r = {$urandom, $urandom};
        r = r % 64'(F_PRIME);
        return r[F_NBITS-1:0];
    endfunction

    initial begin
        rst = 1'b1;
        en1 = 1'b0; en2 = 1'b0; en3 = 1'b0;
        z1 = '0; m1 = '0; z2 = '0; m2 = '0; z3 = '0; m3 = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(rdy2), 64'd1);
        check("rst_pulse", 64'(rp2), 64'd0);
        for (int g = 0; g < 4; g++) check($sformatf("rst_chi%0d", g), 64'(chi2[g*F_NBITS +: F_NBITS]), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(rdy2), 64'd1);

        // Basic 2-variable table.
        z2 = {F_NBITS'(5), F_NBITS'(3)};
        m2 = {F_NBITS'(7), F_NBITS'(2)};
        snap = mc2;
        en2 = 1'b1;
        #1 check("basic_ready_low", 64'(rdy2), 64'd0);
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (rp2 === 1'b1) break;
        end
        check("basic_latency", 64'(k), 64'd14);
        check("basic_chi0", 64'(chi2[0*F_NBITS +: F_NBITS]), 64'd14);
        check("basic_chi1", 64'(chi2[1*F_NBITS +: F_NBITS]), 64'd21);
        check("basic_chi2", 64'(chi2[2*F_NBITS +: F_NBITS]), 64'd10);
        check("basic_chi3", 64'(chi2[3*F_NBITS +: F_NBITS]), 64'd15);
        check("basic_muls", 64'(mc2 - snap), 64'd4);
        @(negedge clk);
        check("basic_pulse_once", 64'(rp2), 64'd0);
        check("basic_ready_back", 64'(rdy2), 64'd1);
        repeat (3) @(negedge clk);
        check("basic_chi3_stable", 64'(chi2[3*F_NBITS +: F_NBITS]), 64'd15);
        en2 = 1'b0;

        // Degenerate 1-variable table.
        z1 = F_NBITS'(9);
        m1 = F_NBITS'(4);
        @(negedge clk);
        snap = mc1;
        en1 = 1'b1;
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            k++;
            if (rp1 === 1'b1) break;
        end
        check("deg_latency", 64'(k), 64'd2);
        check("deg_chi0", 64'(chi1[0 +: F_NBITS]), 64'd4);
        check("deg_chi1", 64'(chi1[F_NBITS +: F_NBITS]), 64'd9);
        check("deg_muls", 64'(mc1 - snap), 64'd0);
        en1 = 1'b0;

        // Latching, and rejection of a restart while busy or in the done cycle.
        @(negedge clk);
        z2 = {rand_fe(), rand_fe()};
        m2 = {rand_fe(), rand_fe()};
        zs = (8*F_NBITS)'(z2);
        ms = (8*F_NBITS)'(m2);
        snap = mc2;
        en2 = 1'b1;
        k = 0;
        bad = 0;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (rp2 === 1'b1) break;
            if (rdy2 !== 1'b0) bad++;
            if (k == 5) begin
                z2 = {rand_fe(), rand_fe()};
                m2 = {rand_fe(), rand_fe()};
                en2 = 1'b0;
            end
            if (k == 6) en2 = 1'b1;
            if (k == 12) en2 = 1'b0;
        end
        en2 = 1'b1;
        check("latch_latency", 64'(k), 64'd14);
        check("latch_ready_low", 64'(bad), 64'd0);
        for (int g = 0; g < 4; g++)
            check($sformatf("latch_chi%0d", g), 64'(chi2[g*F_NBITS +: F_NBITS]), ref_chi(2, zs, ms, g));
        check("latch_muls", 64'(mc2 - snap), 64'd4);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (rp2 === 1'b1) extra++;
        end
        check("done_start_ignored", 64'(extra), 64'd0);
        check("done_start_ready", 64'(rdy2), 64'd1);
        check("done_start_muls", 64'(mc2 - snap), 64'd4);
        en2 = 1'b0;

        // Reset during the multiplier wait, with en held high through release.
        @(negedge clk);
        z2 = {rand_fe(), rand_fe()};
        m2 = {rand_fe(), rand_fe()};
        en2 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) check($sformatf("abort_chi%0d", g), 64'(chi2[g*F_NBITS +: F_NBITS]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        snap = mc2;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (rp2 === 1'b1) extra++;
        end
        check("abort_no_start", 64'(extra), 64'd0);
        check("abort_ready", 64'(rdy2), 64'd1);
        check("abort_muls", 64'(mc2 - snap), 64'd0);
        en2 = 1'b0;

        // Random 3-variable tables with a variable-latency multiplier.
        for (int it = 0; it < 4; it++) begin
            @(negedge clk);
            en3 = 1'b0;
            z3 = {rand_fe(), rand_fe(), rand_fe()};
            m3 = {rand_fe(), rand_fe(), rand_fe()};
            zs = (8*F_NBITS)'(z3);
            ms = (8*F_NBITS)'(m3);
            @(negedge clk);
            snap = mc3;
            en3 = 1'b1;
            k = 0;
            seen = 1'b0;
            while (k < 400) begin
                @(negedge clk);
                k++;
                if (rp3 === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            check($sformatf("rand%0d_done", it), 64'(seen), 64'd1);
            for (int g = 0; g < 8; g++)
                check($sformatf("rand%0d_chi%0d", it, g), 64'(chi3[g*F_NBITS +: F_NBITS]), ref_chi(3, zs, ms, g));
            check($sformatf("rand%0d_muls", it), 64'(mc3 - snap), 64'd12);
        end
        en3 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
